// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display controller.
package seven_seg_pkg;

    // All segments off (segments are active low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} glyphs; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Width of the digit index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational nibble-to-glyph lookup.
module seven_seg_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/seven_seg_mux_ctrl.sv
// Multi-digit seven-segment scanner: prescaler, digit scan, frame snapshot,
// leading-zero suppression, PWM dimming and a registered output stage.
module seven_seg_mux_ctrl
    import seven_seg_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    parameter  int DIVIDE_BY  = 17,
    parameter  int BRIGHT_W   = 3,
    localparam int IDX_W      = idx_width(NUM_DIGITS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_done
);

    logic [DIVIDE_BY-1:0]        prescaler;
    logic                        tick;
    logic                        frame_end;

    // Frame snapshot: the display only ever reads these.
    logic [NUM_DIGITS-1:0][3:0]  sh_digits;
    logic [NUM_DIGITS-1:0]       sh_en;
    logic [NUM_DIGITS-1:0]       sh_dp;
    logic                        sh_lz;
    logic [BRIGHT_W-1:0]         sh_bright;

    logic [NUM_DIGITS-1:0]       suppressed;
    logic                        zero_run;
    logic [3:0]                  nibble;
    logic [6:0]                  glyph;
    logic                        lit;
    logic                        visible;

    assign tick      = &prescaler;
    assign frame_end = tick && (digit_idx == IDX_W'(NUM_DIGITS - 1));

    // Free-running prescaler, digit scan and end-of-frame pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler  <= '0;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            prescaler  <= prescaler + DIVIDE_BY'(1);
            frame_done <= frame_end;
            if (tick) begin
                digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                                   : digit_idx + IDX_W'(1);
            end
        end
    end

    // Snapshot inputs at the frame boundary so a frame never tears.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_digits <= '0;
            sh_en     <= '0;
            sh_dp     <= '0;
            sh_lz     <= 1'b0;
            sh_bright <= '0;
        end else if (frame_end) begin
            sh_digits <= digits;
            sh_en     <= digit_en;
            sh_dp     <= dp_in;
            sh_lz     <= lz_suppress;
            sh_bright <= brightness;
        end
    end

    // Walk down from the top digit; a digit is a leading zero while every
    // nibble at or above it is zero. Digit 0 always shows.
    always_comb begin
        zero_run   = 1'b1;
        suppressed = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run & (sh_digits[i] == 4'h0);
            suppressed[i] = sh_lz & zero_run;
        end
    end

    assign nibble  = sh_digits[digit_idx];
    assign lit     = (prescaler[DIVIDE_BY-1 -: BRIGHT_W] <= sh_bright);
    assign visible = sh_en[digit_idx] & ~suppressed[digit_idx] & lit;

    seven_seg_hex_decode u_decode (
        .nibble (nibble),
        .seg    (glyph)
    );

    // Registered pin drivers; at most one anode is ever low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= visible ? ~(NUM_DIGITS'(1) << digit_idx) : '1;
            seg <= visible ? glyph : SEG_BLANK;
            dp  <= ~(sh_dp[digit_idx] & visible);
        end
    end

endmodule

// File: tb/tb_seven_seg_mux_ctrl.sv
// Bench for seven_seg_mux_ctrl with an 8-cycle slot / 32-cycle frame.
module tb_seven_seg_mux_ctrl;

    localparam int ND    = 4;
    localparam int DIV   = 3;
    localparam int BW    = 3;
    localparam int SLOT  = 1 << DIV;
    localparam int FRAME = SLOT * ND;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits = '0;
    logic [3:0]  digit_en = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_suppress = 1'b0;
    logic [2:0]  brightness = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    // Reference model: cycles since reset release plus the frame snapshot.
    int          n = 0;
    logic [15:0] m_digits = '0;
    logic [3:0]  m_en = '0;
    logic [3:0]  m_dp = '0;
    logic        m_lz = 1'b0;
    logic [2:0]  m_br = '0;

    typedef struct packed {
        logic [15:0]     digits;
        logic [3:0]      en;
        logic [3:0]      dpi;
        logic            lz;
        logic [2:0]      br;
        logic [3:0][3:0] an;
        logic [3:0][6:0] seg;
        logic [3:0]      dpo;
        logic [3:0][3:0] cnt;
    } vec_t;

    vec_t tbl [8];

    seven_seg_mux_ctrl #(
        .NUM_DIGITS (ND),
        .DIVIDE_BY  (DIV),
        .BRIGHT_W   (BW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .digits      (digits),
        .digit_en    (digit_en),
        .dp_in       (dp_in),
        .lz_suppress (lz_suppress),
        .brightness  (brightness),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .digit_idx   (digit_idx),
        .frame_done  (frame_done)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock: predict from the model, advance, compare every output.
    task automatic step();
        int p, d, nib;
        bit supp, lit, vis;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_dp;
        p     = n % SLOT;
        d     = (n / SLOT) % ND;
        nib   = int'((m_digits >> (4 * d)) & 16'hF);
        supp  = m_lz && (d >= 1) && ((m_digits >> (4 * d)) == 16'h0);
        lit   = (p >> (DIV - BW)) <= int'(m_br);
        vis   = m_en[d] && !supp && lit;
        e_an  = vis ? ~(4'b0001 << d) : 4'hF;
        e_seg = vis ? GLYPH[nib] : 7'h7F;
        e_dp  = !(m_dp[d] && vis);
        @(posedge clock);
        if (reset) begin
            n = 0; m_digits = '0; m_en = '0; m_dp = '0; m_lz = 1'b0; m_br = '0;
        end else begin
            n++;
            if (n % FRAME == 0) begin
                m_digits = digits; m_en = digit_en; m_dp = dp_in;
                m_lz = lz_suppress; m_br = brightness;
            end
        end
        #1;
        if (reset) begin
            chk("rst_an", an, 4'hF);
            chk("rst_seg", seg, 7'h7F);
            chk("rst_dp", dp, 1);
            chk("rst_digit_idx", digit_idx, 0);
            chk("rst_frame_done", frame_done, 0);
        end else begin
            chk("model_an", an, e_an);
            chk("model_seg", seg, e_seg);
            chk("model_dp", dp, e_dp);
            chk("model_digit_idx", digit_idx, (n / SLOT) % ND);
            chk("model_frame_done", frame_done, (n % FRAME == 0) ? 1 : 0);
        end
        chk("an_onehot", ($countones(~an) <= 1) ? 1 : 0, 1);
    endtask

    // Advance until just after the next snapshot edge.
    task automatic sync_frame();
        step();
        for (int k = 0; k < FRAME && (n % FRAME) != 0; k++) step();
        chk("frame_sync", frame_done, 1);
    endtask

    initial begin
        int cyc, lit_cnt;
        bit found;

        tbl[0] = '{16'h1234, 4'hF, 4'h0, 1'b0, 3'd7,
                   {4'h7, 4'hB, 4'hD, 4'hE},
                   {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
                   4'hF, {4'd8, 4'd8, 4'd8, 4'd8}};
        tbl[1] = '{16'h0050, 4'hF, 4'h0, 1'b1, 3'd7,
                   {4'hF, 4'hF, 4'hD, 4'hE},
                   {7'h7F, 7'h7F, 7'b0010010, 7'b1000000},
                   4'hF, {4'd0, 4'd0, 4'd8, 4'd8}};
        tbl[2] = '{16'h0050, 4'hF, 4'h0, 1'b0, 3'd7,
                   {4'h7, 4'hB, 4'hD, 4'hE},
                   {7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000},
                   4'hF, {4'd8, 4'd8, 4'd8, 4'd8}};
        tbl[3] = '{16'h1234, 4'hF, 4'b0100, 1'b0, 3'd0,
                   {4'h7, 4'hB, 4'hD, 4'hE},
                   {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
                   4'b1011, {4'd1, 4'd1, 4'd1, 4'd1}};
        tbl[4] = '{16'h1234, 4'hF, 4'h0, 1'b0, 3'd3,
                   {4'h7, 4'hB, 4'hD, 4'hE},
                   {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
                   4'hF, {4'd4, 4'd4, 4'd4, 4'd4}};
        tbl[5] = '{16'hABCD, 4'b1010, 4'h0, 1'b0, 3'd7,
                   {4'h7, 4'hF, 4'hD, 4'hF},
                   {7'b0001000, 7'h7F, 7'b1000110, 7'h7F},
                   4'hF, {4'd8, 4'd0, 4'd8, 4'd0}};
        tbl[6] = '{16'h0000, 4'hF, 4'h0, 1'b1, 3'd7,
                   {4'hF, 4'hF, 4'hF, 4'hE},
                   {7'h7F, 7'h7F, 7'h7F, 7'b1000000},
                   4'hF, {4'd0, 4'd0, 4'd0, 4'd8}};
        tbl[7] = '{16'h0F00, 4'hF, 4'hF, 1'b1, 3'd7,
                   {4'hF, 4'hB, 4'hD, 4'hE},
                   {7'h7F, 7'b0001110, 7'b1000000, 7'b1000000},
                   4'b1000, {4'd0, 4'd8, 4'd8, 4'd8}};

        // Reset held for five clocks, then first frame_done 32 clocks later.
        repeat (5) step();
        reset = 1'b0;
        cyc = 0; found = 1'b0;
        while (!found && cyc < 40) begin
            step();
            cyc++;
            if (frame_done) found = 1'b1;
        end
        chk("first_frame_done_latency", cyc, 32);

        // Table vectors: snapshot, then inspect every slot of one frame.
        for (int v = 0; v < 8; v++) begin
            digits = tbl[v].digits; digit_en = tbl[v].en; dp_in = tbl[v].dpi;
            lz_suppress = tbl[v].lz; brightness = tbl[v].br;
            sync_frame();
            for (int s = 0; s < ND; s++) begin
                lit_cnt = 0;
                step();
                chk($sformatf("vec%0d_slot%0d_an", v, s), an, tbl[v].an[s]);
                chk($sformatf("vec%0d_slot%0d_seg", v, s), seg, tbl[v].seg[s]);
                chk($sformatf("vec%0d_slot%0d_dp", v, s), dp, tbl[v].dpo[s]);
                if (an != 4'hF) lit_cnt++;
                repeat (SLOT - 1) begin
                    step();
                    if (an != 4'hF) lit_cnt++;
                end
                chk($sformatf("vec%0d_slot%0d_lit_cycles", v, s), lit_cnt, tbl[v].cnt[s]);
            end
        end

        // Mid-frame input change only shows after the next snapshot.
        digits = 16'h1234; digit_en = 4'hF; dp_in = 4'h0; lz_suppress = 1'b0; brightness = 3'd7;
        sync_frame();
        repeat (12) step();
        digits = 16'hABCD;
        repeat (5) step();
        chk("tear_slot2_still_old", seg, 7'b0100100);
        repeat (8) step();
        chk("tear_slot3_still_old", seg, 7'b1111001);
        repeat (7) step();
        chk("tear_snapshot_edge", frame_done, 1);
        step();
        chk("tear_slot0_new", seg, 7'b0100001);

        // Asynchronous reset between edges clears pins before the next edge.
        repeat (10) step();
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_an", an, 4'hF);
        chk("async_rst_seg", seg, 7'h7F);
        chk("async_rst_dp", dp, 1);
        chk("async_rst_digit_idx", digit_idx, 0);
        chk("async_rst_frame_done", frame_done, 0);
        repeat (2) step();
        reset = 1'b0;
        lit_cnt = 0;
        repeat (FRAME) begin
            step();
            if (an != 4'hF) lit_cnt++;
        end
        chk("post_rst_blank_frame", lit_cnt, 0);
        chk("post_rst_frame_done", frame_done, 1);

        // Random inputs changing at arbitrary cycles, checked by the model.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                digits      = 16'($urandom) & 16'(32'hFFFF >> (4 * $urandom_range(0, 4)));
                digit_en    = 4'($urandom);
                dp_in       = 4'($urandom);
                lz_suppress = 1'($urandom);
                brightness  = 3'($urandom);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
